mux_rr_arb: RTL and testbench
=============================

# mux_rr_arb

Parametrised N-channel, WIDTH-bit arbitrating multiplexer with valid/ready handshakes and a registered output. It is the successor to the plain 2:1 select mux: a round-robin arbiter generates the select internally instead of taking it as an input. The CPU uses it to merge several requesters onto one shared port, for example instruction-fetch and data requests onto a single memory bus.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (N >= 2)
- SELW, $clog2(N), width of the granted-channel index (derived; do not override)

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  N  per-channel request valid
- in_data  in  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept, one-hot or zero
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered data of the granted channel
- out_sel  out  SELW  index of the channel whose data is in out_data
- out_ready  in  1  downstream accepts out_data this cycle

## Operation
- Output register state: EMPTY when out_valid=0, FULL when out_valid=1.
- can_load = ~out_valid | out_ready. A FULL register that drains in the same cycle can load a new word.
- Arbitration is combinational and evaluated every cycle:
  - The priority pointer ptr (SELW bits) names the highest-priority channel.
  - Search order: ptr, ptr+1, ..., wrapping mod N.
  - The first channel with in_valid=1 wins.
- in_ready[win] = can_load & any in_valid. All other in_ready bits are 0. in_ready does not depend on in_ready itself.
- Transfer on channel i happens when in_valid[i] & in_ready[i]. On a transfer:
  - out_data <= in_data[i], out_sel <= i, out_valid <= 1
  - ptr <= (i+1) mod N. When N is not a power of two, wrap explicitly: i = N-1 goes to 0.
- Drain without a load (out_valid & out_ready, no transfer): out_valid <= 0. out_data and out_sel hold their old values.
- No transfer and no drain: all state holds.
- No requests: ptr holds and in_ready is all zero.
- Inputs must hold in_valid and in_data until accepted. The block does not check this.
- Fairness: a continuously requesting channel is served within N transfers.

## Timing
- Reset (resetn=0, asynchronous) sets:
  - out_valid=0, out_data=0, out_sel=0, ptr=0
  - in_ready reads 0 during reset.
- Latency is 1 cycle: a word accepted at edge k appears with out_valid=1 after edge k.
- Throughput is one word per cycle while out_ready=1.
- Simultaneous drain and load in one cycle: the new word replaces the old, out_valid stays 1, and no bubble is inserted.
- Back-pressure: with out_ready=0 and out_valid=1, all in_ready are 0 and out_data is stable.
- Reset asserted mid-transfer: the word in flight is discarded and ptr returns to 0.
- After reset deasserts, the first arbitration favours channel 0.

## Structure
- Shared package cpu_pkg holds the default data-width constant (32). No typedefs are needed.
- Sub-module rr_pick, purely combinational:
  - inputs: req[N], ptr[SELW]
  - outputs: gnt[N] one-hot, gnt_idx[SELW], any
  - Implementation: rotate, find first set, rotate back. Top level holds ptr and the output register.

## Test plan
- Reset check: N=4, hold resetn=0 with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. After release, first grant goes to channel 0.
- Single channel: only ch2 valid with data 0xA5A5_0002, out_ready=1 -> in_ready=0100, next cycle out_valid=1, out_data=0xA5A5_0002, out_sel=2. After that transfer, the next grant search starts at ch3.
- Full contention: all 4 channels valid every cycle, out_ready=1 -> out_sel sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
- Back-pressure: out_ready=0 for 3 cycles while FULL -> in_ready=0000, out_data stable. When out_ready rises, drain and load happen in the same cycle.
- Non-power-of-two N=3: ch2 granted, then all valid -> next grant is ch0 (wrap). out_sel never reaches 3.
- Mid-operation reset: pulse resetn low for half a cycle while FULL with out_sel=3 -> out_valid drops immediately (asynchronous) and ptr=0, so ch0 wins next.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants used by datapath blocks.
package cpu_pkg;
    localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/mux_rr_arb_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, find first set, rotate back.
module rr_pick
    import cpu_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);
    logic [2*N-1:0] dbl_s;
    logic [2*N-1:0] shifted_s;
    logic [N-1:0]   rot_s;
    logic [SELW-1:0] off_s;
    logic [SELW:0]   sum_s;
    logic            found_s;

    assign dbl_s     = {req, req};
    assign shifted_s = dbl_s >> ptr;
    assign rot_s     = shifted_s[N-1:0];

    // Lowest set bit of the rotated vector is the offset from ptr; scan downward so it wins.
    always_comb begin
        off_s   = {SELW{1'b0}};
        found_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s   = SELW'(i);
                found_s = 1'b1;
            end else begin
                off_s   = off_s;
                found_s = found_s;
            end
        end
    end

    // Rotate back: explicit wrap keeps non-power-of-two N in range.
    always_comb begin
        sum_s = {1'b0, off_s} + {1'b0, ptr};
        if (sum_s >= (SELW+1)'(N)) begin
            gnt_idx = SELW'(sum_s - (SELW+1)'(N));
        end else begin
            gnt_idx = SELW'(sum_s);
        end
    end

    // One-hot grant derived from the index.
    always_comb begin
        gnt = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            gnt[i] = found_s && (gnt_idx == SELW'(i));
        end
    end

    assign any = found_s;
endmodule

// File: rtl/mux_rr_arb.sv
// N-channel round-robin arbitrating mux with valid/ready handshakes and a registered output.
module mux_rr_arb
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);
    logic [SELW-1:0]  ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_sel_r;

    logic [N-1:0]     gnt_s;
    logic [SELW-1:0]  gnt_idx_s;
    logic             any_s;
    logic             can_load_s;
    logic             xfer_s;
    logic [SELW-1:0]  ptr_next_s;

    rr_pick #(.N(N), .SELW(SELW)) u_pick (
        .req     (in_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // resetn gates the accept so nothing is offered while reset is held.
    assign can_load_s = ~out_valid_r | out_ready;
    assign xfer_s     = resetn & can_load_s & any_s;
    assign in_ready   = xfer_s ? gnt_s : {N{1'b0}};
    assign ptr_next_s = (gnt_idx_s == SELW'(N - 1)) ? {SELW{1'b0}} : gnt_idx_s + SELW'(1);

    // Output register and priority pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r       <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SELW{1'b0}};
        end else if (xfer_s) begin
            ptr_r       <= ptr_next_s;
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
            out_sel_r   <= gnt_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb at N=4 and N=3 with directed and random stimulus.
module tb_mux_rr_arb;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]     v4 = 4'd0;
    logic [4*W-1:0] d4;
    logic [3:0]     ir4;
    logic           ov4;
    logic [W-1:0]   od4;
    logic [1:0]     os4;
    logic           rdy4 = 1'b0;

    logic [2:0]     v3 = 3'd0;
    logic [3*W-1:0] d3;
    logic [2:0]     ir3;
    logic           ov3;
    logic [W-1:0]   od3;
    logic [1:0]     os3;
    logic           rdy3 = 1'b0;

    logic [W-1:0] dat [2][4];

    always_comb begin
        for (int i = 0; i < 4; i++) d4[i*W +: W] = dat[0][i];
        for (int i = 0; i < 3; i++) d3[i*W +: W] = dat[1][i];
    end

    mux_rr_arb #(.WIDTH(W), .N(4)) u4 (
        .clk(clk), .resetn(resetn), .in_valid(v4), .in_data(d4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(rdy4)
    );

    mux_rr_arb #(.WIDTH(W), .N(3)) u3 (
        .clk(clk), .resetn(resetn), .in_valid(v3), .in_data(d3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(rdy3)
    );

    int checks = 0;
    int passed = 0;

    exp_t q4[$];
    exp_t q3[$];
    int   ptr_m[2];
    bit   full_m[2];
    int   last_win[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Drive one cycle on DUT d; rnd chooses valids/data by the hold rule instead of v.
    task automatic step(input int d, input logic [3:0] v, input logic rdy, input bit rnd);
        int         nch;
        int         win;
        logic [3:0] vv;
        logic [3:0] exp_ir;
        logic       can;
        nch = (d == 0) ? 4 : 3;
        win = -1;
        exp_ir = 4'd0;
        @(negedge clk);
        vv = v;
        if (rnd) begin
            vv = (d == 0) ? v4 : {1'b0, v3};
            for (int c = 0; c < nch; c++) begin
                if (!vv[c] || last_win[d] == c) begin
                    vv[c] = ($urandom_range(0, 9) < 6);
                    dat[d][c] = $urandom;
                end
            end
        end
        if (d == 0) begin
            v4 = vv; rdy4 = rdy; v3 = 3'd0; rdy3 = 1'b0;
        end else begin
            v3 = vv[2:0]; rdy3 = rdy; v4 = 4'd0; rdy4 = 1'b0;
        end
        #2;
        can = !full_m[d] || rdy;
        for (int k = 0; k < nch; k++) begin
            int c;
            c = (ptr_m[d] + k) % nch;
            if (win < 0 && vv[c]) win = c;
        end
        if (resetn && can && win >= 0) exp_ir[win] = 1'b1;
        if (d == 0) begin
            chk("in_ready4", ir4, exp_ir);
            chk("out_valid4", ov4, full_m[0]);
        end else begin
            chk("in_ready3", ir3, exp_ir[2:0]);
            chk("out_valid3", ov3, full_m[1]);
        end
        if (exp_ir != 4'd0) begin
            exp_t e;
            e.sel = 2'(win);
            e.data = dat[d][win];
            if (d == 0) q4.push_back(e); else q3.push_back(e);
            ptr_m[d] = (win + 1) % nch;
            full_m[d] = 1'b1;
            last_win[d] = win;
        end else begin
            if (full_m[d] && rdy) full_m[d] = 1'b0;
            last_win[d] = -1;
        end
    endtask

    // Monitors: every accepted output word is compared with the oldest expected entry.
    initial forever begin
        @(negedge clk);
        #3;
        if (resetn && ov4 && rdy4) begin
            if (q4.size() == 0) fail("unexpected_word4");
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("out_sel4", os4, e.sel);
                chk("out_data4", od4, e.data);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #3;
        if (resetn && ov3 && rdy3) begin
            if (q3.size() == 0) fail("unexpected_word3");
            else begin
                exp_t e;
                e = q3.pop_front();
                chk("out_sel3", os3, e.sel);
                chk("out_data3", od3, e.data);
            end
        end
    end

    task automatic model_reset();
        q4.delete();
        q3.delete();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d] = 0;
            full_m[d] = 1'b0;
            last_win[d] = -1;
        end
    endtask

    initial begin
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) dat[d][c] = 32'hA5A5_0000 | 32'(c);

        // Reset held with every channel requesting.
        v4 = 4'hF; rdy4 = 1'b1;
        #22;
        chk("rst_in_ready", ir4, 4'b0000);
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_data", od4, 32'd0);
        chk("rst_out_sel", os4, 2'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step(0, 4'hF, 1'b1, 1'b0);

        // Single channel ch2, then search resumes from ch3.
        step(0, 4'b0100, 1'b1, 1'b0);
        chk("single_ch2_ready", ir4, 4'b0100);
        step(0, 4'b1011, 1'b1, 1'b0);
        chk("after_ch2_ch3", ir4, 4'b1000);

        // Full contention.
        for (int n = 0; n < 6; n++) step(0, 4'hF, 1'b1, 1'b0);

        // Back-pressure then simultaneous drain and load.
        for (int n = 0; n < 3; n++) begin
            step(0, 4'hF, 1'b0, 1'b0);
            chk("bp_data_stable", od4, 32'hA5A5_0000 | 32'(os4));
        end
        step(0, 4'hF, 1'b1, 1'b0);

        // Load ch3, then pulse reset for half a cycle while full.
        step(0, 4'b1000, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        v4 = 4'd0; rdy4 = 1'b0; v3 = 3'd0; rdy3 = 1'b0;
        chk("pre_rst_sel3", os4, 2'd3);
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", ov4, 1'b0);
        model_reset();
        #4 resetn = 1'b1;
        step(0, 4'hF, 1'b1, 1'b0);
        chk("post_rst_ch0", ir4, 4'b0001);

        // N=3: ch2, then wrap to ch0.
        step(1, 4'b0100, 1'b1, 1'b0);
        step(1, 4'b0111, 1'b1, 1'b0);
        chk("n3_wrap_ch0", ir3, 3'b001);
        for (int n = 0; n < 4; n++) step(1, 4'b0111, 1'b1, 1'b0);

        // Randomized traffic with back-pressure.
        for (int n = 0; n < 300; n++) step(0, 4'd0, ($urandom_range(0, 3) != 0), 1'b1);
        for (int n = 0; n < 200; n++) step(1, 4'd0, ($urandom_range(0, 3) != 0), 1'b1);

        // Drain everything.
        for (int n = 0; n < 2; n++) step(0, 4'd0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) step(1, 4'd0, 1'b1, 1'b0);
        #5;
        chk("q4_empty", q4.size(), 0);
        chk("q3_empty", q3.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
